operand_reg_stream: RTL and testbench
=====================================

Name: operand_reg_stream

Overview:
- Parametrised successor to the single-port operand register.
- Holds one MATRIX_DIM x MATRIX_DIM operand matrix and provides:
  - a bus write port with byte strobes,
  - a registered bus read port,
  - a row/column streaming engine with valid/ready handshake.
- Sits between the host register interface and the matrix-multiply datapath, which consumes one full row (or column, in transpose mode) per accepted beat.

Parameters:
- DATA_WIDTH, 32, element width in bits. Must be a multiple of 8.
- MATRIX_DIM, 4, matrix side length. Must be a power of two, >= 2.
- ADDR_WIDTH, 4, element address width. Must equal 2*log2(MATRIX_DIM).
- IDX_WIDTH, 2, stream index width. Must equal log2(MATRIX_DIM).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- write_data_Mat_i  in  DATA_WIDTH  bus write data.
- addr_Mat_i  in  ADDR_WIDTH  element address. addr = row*MATRIX_DIM + col.
- write_en_Mat_i  in  1  bus write enable.
- strb_Mat_i  in  DATA_WIDTH/8  byte strobes for the bus write.
- read_data_Mat_o  out  DATA_WIDTH  registered bus read data.
- stream_start_i  in  1  start pulse for a matrix stream.
- stream_transpose_i  in  1  sampled with start: 0 = rows, 1 = columns.
- stream_data_o  out  MATRIX_DIM*DATA_WIDTH  one row or column. Lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- stream_valid_o  out  1  beat valid.
- stream_ready_i  in  1  consumer ready.
- stream_idx_o  out  IDX_WIDTH  current row/column index.
- stream_last_o  out  1  high with the final beat.
- busy_o  out  1  stream in progress.
- wr_err_o  out  1  one-cycle pulse: a write was rejected.

Behaviour:
- Reset is synchronous and active-high. While rst_i is high at a clock edge:
  - all matrix elements clear to 0,
  - state goes to IDLE,
  - read_data_Mat_o, stream_valid_o, stream_idx_o, stream_last_o, busy_o and wr_err_o all clear to 0,
  - stream_data_o reads all zeros.
- Reset mid-stream aborts the stream immediately. No further beats are issued.
- Bus write (state IDLE, write_en_Mat_i=1):
  - For each byte b with strb_Mat_i[b]=1, mem[addr][8b+7:8b] <= write_data_Mat_i[8b+7:8b] at the clock edge.
  - Bytes with strobe 0 are unchanged.
- Bus read:
  - read_data_Mat_o <= mem[addr_Mat_i] every cycle, regardless of write_en or state. Latency is 1 cycle.
  - Same-cycle write and read of the same address returns the OLD value. The new value is visible on the following cycle's read.
- State IDLE:
  - busy_o=0, stream_valid_o=0.
  - If stream_start_i=1: latch stream_transpose_i, set idx=0, go to STREAM. stream_valid_o=1 from the next cycle.
  - A write in the same cycle as start commits, and the streamed data includes it.
- State STREAM:
  - busy_o=1, stream_valid_o=1.
  - Row mode: lane k = mem[idx*MATRIX_DIM + k].
  - Transpose mode: lane k = mem[k*MATRIX_DIM + idx].
  - stream_data_o is combinational from storage and idx. It stays stable while valid and !ready, because writes are blocked.
  - stream_last_o = (idx == MATRIX_DIM-1).
  - Transfer occurs when valid & ready at the edge:
    - if not last: idx increments;
    - if last: go to IDLE, idx=0, valid=0.
  - Back-to-back transfers are allowed: one beat per cycle when ready is held high.
  - stream_start_i is ignored while in STREAM.
- Write during STREAM:
  - storage is unchanged,
  - wr_err_o=1 on the next cycle for exactly one cycle per rejected write,
  - the read port still operates.
- Addresses are always in range, since ADDR_WIDTH covers MATRIX_DIM^2 exactly. There is no wrap-around handling.

Test Plan (DATA_WIDTH=32, MATRIX_DIM=4):
- Reset, then write addr 0 = 8 and addr 2 = 88 with strb=4'hF. Read addr 0 then addr 2 → read_data=8, then 88, each one cycle after the address is applied. Read of addr 5 → 0.
- Write addr 3 = 32'hAABBCCDD with strb=4'hF, then write 32'h11223344 with strb=4'b0101 → readback 32'hAA22CC44.
- Fill mem[i]=i+1. Start with transpose=0, ready=1 → 4 consecutive beats, idx 0..3. Beat 0 = {4,3,2,1} (lane3..lane0). last high only on beat 3. busy drops the cycle after beat 3.
- Same fill, transpose=1, ready toggled 1,0,0,1,... → beat 0 = {13,9,5,1}, held stable through the ready=0 cycles. Exactly 4 transfers occur.
- During STREAM, write addr 0 = 99 → wr_err_o pulses once; readback of addr 0 is unchanged; the streamed data is unchanged.
- Assert rst_i after beat 1 of a stream → next cycle valid=0, busy=0, idx=0, all reads return 0. A new start streams all-zero rows.

Source files
------------

// File: rtl/operand_reg_stream.sv
// Operand matrix store: byte-strobed bus write, registered bus read, row/column stream engine.
// Latency: bus read 1 cycle; first stream beat valid the cycle after start, then one beat per accepted cycle.
// Backpressure: a beat is held stable while stream_ready_i is low; bus writes during a stream are rejected.
module operand_reg_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int MATRIX_DIM = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [DATA_WIDTH-1:0]            write_data_Mat_i,
  input  logic [ADDR_WIDTH-1:0]            addr_Mat_i,
  input  logic                             write_en_Mat_i,
  input  logic [DATA_WIDTH/8-1:0]          strb_Mat_i,
  output logic [DATA_WIDTH-1:0]            read_data_Mat_o,
  input  logic                             stream_start_i,
  input  logic                             stream_transpose_i,
  output logic [MATRIX_DIM*DATA_WIDTH-1:0] stream_data_o,
  output logic                             stream_valid_o,
  input  logic                             stream_ready_i,
  output logic [IDX_WIDTH-1:0]             stream_idx_o,
  output logic                             stream_last_o,
  output logic                             busy_o,
  output logic                             wr_err_o
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = MATRIX_DIM * MATRIX_DIM;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(MATRIX_DIM - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  xpose_q, xpose_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_ok;
  logic is_last;

  assign wr_ok   = write_en_Mat_i && (state_q == IDLE);
  assign is_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      xpose_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      xpose_q <= xpose_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xpose_d = xpose_q;
    case (state_q)
      IDLE: begin
        if (stream_start_i) begin
          state_d = STREAM;
          idx_d   = '0;
          xpose_d = stream_transpose_i;
        end
      end
      STREAM: begin
        if (stream_ready_i) begin
          if (is_last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Storage is frozen while streaming so a stalled beat cannot change under the consumer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (strb_Mat_i[b]) begin
          mem[addr_Mat_i][8*b +: 8] <= write_data_Mat_i[8*b +: 8];
        end
      end
    end
  end

  // Read samples pre-write contents, so a same-cycle write shows up one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      read_data_Mat_o <= '0;
      wr_err_o        <= 1'b0;
    end else begin
      read_data_Mat_o <= mem[addr_Mat_i];
      wr_err_o        <= write_en_Mat_i && (state_q == STREAM);
    end
  end

  for (genvar k = 0; k < MATRIX_DIM; k++) begin : g_lane
    logic [ADDR_WIDTH-1:0] lane_addr;
    assign lane_addr = xpose_q ? {IDX_WIDTH'(k), idx_q} : {idx_q, IDX_WIDTH'(k)};
    assign stream_data_o[k*DATA_WIDTH +: DATA_WIDTH] = mem[lane_addr];
  end

  assign stream_valid_o = (state_q == STREAM);
  assign busy_o         = (state_q == STREAM);
  assign stream_idx_o   = idx_q;
  assign stream_last_o  = (state_q == STREAM) && is_last;

endmodule

// File: tb/tb_operand_reg_stream.sv
// Directed bench for operand_reg_stream with a cycle-level reference model and per-cycle compare.
module tb_operand_reg_stream;

  localparam int W = 32;
  localparam int D = 4;
  localparam int A = 4;
  localparam int I = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0]      wdata;
  logic [A-1:0]      addr;
  logic              we;
  logic [W/8-1:0]    strb;
  logic [W-1:0]      rdata;
  logic              start;
  logic              tr;
  logic [D*W-1:0]    sdata;
  logic              svalid;
  logic              sready;
  logic [I-1:0]      sidx;
  logic              slast;
  logic              busy;
  logic              werr;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  operand_reg_stream #(.DATA_WIDTH(W), .MATRIX_DIM(D), .ADDR_WIDTH(A), .IDX_WIDTH(I)) dut (
    .clk_i(clk), .rst_i(rst),
    .write_data_Mat_i(wdata), .addr_Mat_i(addr), .write_en_Mat_i(we), .strb_Mat_i(strb),
    .read_data_Mat_o(rdata),
    .stream_start_i(start), .stream_transpose_i(tr),
    .stream_data_o(sdata), .stream_valid_o(svalid), .stream_ready_i(sready),
    .stream_idx_o(sidx), .stream_last_o(slast), .busy_o(busy), .wr_err_o(werr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [D*W-1:0] act, input logic [D*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: matrix array plus stream position, advanced once per clock edge.
  int unsigned m_mem [D*D];
  bit          m_busy  = 0;
  bit          m_xp    = 0;
  int          m_idx   = 0;
  int unsigned m_rd    = 0;
  bit          m_err   = 0;

  function automatic logic [D*W-1:0] model_beat();
    logic [D*W-1:0] v;
    v = '0;
    for (int k = 0; k < D; k++)
      v[k*W +: W] = m_xp ? m_mem[k*D + m_idx] : m_mem[m_idx*D + k];
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D*D; i++) m_mem[i] = 0;
      m_busy = 0; m_idx = 0; m_rd = 0; m_err = 0; m_xp = 0;
    end else begin
      m_rd  = m_mem[addr];
      m_err = we && m_busy;
      if (!m_busy) begin
        if (we)
          for (int b = 0; b < W/8; b++)
            if (strb[b]) m_mem[addr][8*b +: 8] = wdata[8*b +: 8];
        if (start) begin
          m_busy = 1; m_xp = tr; m_idx = 0;
        end
      end else if (sready) begin
        if (m_idx == D-1) begin
          m_busy = 0; m_idx = 0;
        end else begin
          m_idx++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_rdata", rdata, m_rd);
      check("model_valid", svalid, m_busy);
      check("model_busy", busy, m_busy);
      check("model_idx", sidx, m_idx);
      check("model_last", slast, m_busy && m_idx == D-1);
      check("model_wr_err", werr, m_err);
      if (m_busy) check("model_data", sdata, model_beat());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [D*W-1:0] pack4(input int l3, input int l2, input int l1, input int l0);
    return {W'(l3), W'(l2), W'(l1), W'(l0)};
  endfunction

  initial begin
    int n;
    int xfers;
    logic [D*W-1:0] row0, col0;
    bit [7:0] pat;
    row0 = pack4(4, 3, 2, 1);
    col0 = pack4(13, 9, 5, 1);
    pat  = 8'b1011_0100;

    rst = 1; wdata = '0; addr = '0; we = 0; strb = '0; start = 0; tr = 0; sready = 0;
    tick();
    cmp_en = 1;
    tick();
    check("reset_rdata", rdata, 0);
    check("reset_valid", svalid, 0);
    check("reset_busy", busy, 0);
    check("reset_data", sdata, 0);
    rst = 0;

    // Basic write and readback
    we = 1; strb = 4'hF; addr = 0; wdata = 8; tick();
    addr = 2; wdata = 88; tick();
    we = 0; addr = 0; tick();
    check("read_addr0", rdata, 8);
    addr = 2; tick();
    check("read_addr2", rdata, 88);
    addr = 5; tick();
    check("read_addr5", rdata, 0);

    // Byte strobes
    we = 1; addr = 3; wdata = 32'hAABBCCDD; strb = 4'hF; tick();
    wdata = 32'h11223344; strb = 4'b0101; tick();
    we = 0; tick();
    check("strobe_merge", rdata, 32'hAA22CC44);

    // Fill mem[i] = i+1
    strb = 4'hF;
    for (int i = 0; i < D*D; i++) begin
      we = 1; addr = A'(i); wdata = W'(i + 1); tick();
    end
    we = 0; addr = 0;

    // Row stream, ready held high
    sready = 1; start = 1; tr = 0; tick();
    start = 0;
    n = 0;
    for (int c = 0; c < 20 && n < D; c++) begin
      if (svalid) begin
        if (n == 0) check("row_beat0", sdata, row0);
        check("row_idx", sidx, n);
        check("row_last", slast, n == D-1);
        n++;
      end
      tick();
    end
    check("row_beats", n, D);
    check("row_busy_after", busy, 0);

    // Column stream with ready toggling
    sready = 0; start = 1; tr = 1; tick();
    start = 0;
    xfers = 0;
    for (int c = 0; c < 40; c++) begin
      sready = pat[c % 8];
      if (svalid && sidx == 0) check("col_beat0_stable", sdata, col0);
      if (svalid && sready) xfers++;
      tick();
      if (!busy) break;
    end
    sready = 0;
    check("col_transfers", xfers, D);
    check("col_busy_after", busy, 0);

    // Write rejected while streaming
    start = 1; tr = 0; tick();
    start = 0;
    we = 1; addr = 0; wdata = 99; tick();
    we = 0;
    check("wr_err_pulse", werr, 1);
    check("data_during_err", sdata, row0);
    tick();
    check("wr_err_single", werr, 0);
    check("read_after_reject", rdata, 1);
    sready = 1;
    for (int c = 0; c < 20 && busy; c++) tick();
    check("reject_stream_done", busy, 0);

    // Reset after beat 1 of a stream
    start = 1; tr = 0; tick();
    start = 0;
    tick();
    tick();
    rst = 1; tick();
    check("rst_valid", svalid, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", sidx, 0);
    rst = 0; addr = 7; tick();
    check("rst_read7", rdata, 0);
    start = 1; tick();
    start = 0;
    n = 0;
    for (int c = 0; c < 20 && n < D; c++) begin
      if (svalid) begin
        check("zero_row", sdata, 0);
        n++;
      end
      tick();
    end
    check("zero_beats", n, D);

    tick();
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
